// File: rtl/model_wb_initiator_if.sv
// Command, write-data, read-data/status and Wishbone B3 classic signals of the
// bus initiator. The master modport is the initiator; slave is everything it talks to.
interface model_wb_initiator_if #(
    parameter int LEN_W = 4
);
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic             i_cmd_we;
    logic [31:0]      i_cmd_adr;
    logic [3:0]       i_cmd_sel;
    logic [LEN_W-1:0] i_cmd_len;

    logic             i_wdat_valid;
    logic             o_wdat_ready;
    logic [31:0]      i_wdat;

    logic             o_rdat_valid;
    logic [31:0]      o_rdat;
    logic             o_rdat_last;
    logic             o_done;
    logic             o_err;

    logic             o_wb_cyc;
    logic             o_wb_stb;
    logic             o_wb_we;
    logic [31:0]      o_wb_adr;
    logic [31:0]      o_wb_dat;
    logic [3:0]       o_wb_sel;
    logic [2:0]       o_wb_cti;
    logic [1:0]       o_wb_bte;
    logic             i_wb_ack;
    logic [31:0]      i_wb_dat;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_sel, i_cmd_len,
        input  i_wdat_valid, i_wdat,
        input  i_wb_ack, i_wb_dat,
        output o_cmd_ready, o_wdat_ready,
        output o_rdat_valid, o_rdat, o_rdat_last, o_done, o_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
        output o_wb_cti, o_wb_bte
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_sel, i_cmd_len,
        output i_wdat_valid, i_wdat,
        output i_wb_ack, i_wb_dat,
        input  o_cmd_ready, o_wdat_ready,
        input  o_rdat_valid, o_rdat, o_rdat_last, o_done, o_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
        input  o_wb_cti, o_wb_bte
    );
endinterface

// File: rtl/model_wb_initiator.sv
// Wishbone B3 classic initiator: turns single/linear-burst commands into bus
// cycles, returns read beats and a done/error pulse per command.
module model_wb_initiator #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 256
) (
    input logic                 i_clk,
    input logic                 i_reset,
    model_wb_initiator_if.master bus
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] CTI_SINGLE = 3'b000;
    localparam logic [2:0] CTI_INCR   = 3'b010;
    localparam logic [2:0] CTI_END    = 3'b111;

    typedef enum logic [1:0] {IDLE, WDAT, BUS, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] beat_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    assign bus.o_wb_bte = 2'b00;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= IDLE;
            beat_cnt         <= '0;
            tmo_cnt          <= '0;
            bus.o_cmd_ready  <= 1'b1;
            bus.o_wdat_ready <= 1'b0;
            bus.o_rdat_valid <= 1'b0;
            bus.o_rdat       <= '0;
            bus.o_rdat_last  <= 1'b0;
            bus.o_done       <= 1'b0;
            bus.o_err        <= 1'b0;
            bus.o_wb_cyc     <= 1'b0;
            bus.o_wb_stb     <= 1'b0;
            bus.o_wb_we      <= 1'b0;
            bus.o_wb_adr     <= '0;
            bus.o_wb_dat     <= '0;
            bus.o_wb_sel     <= '0;
            bus.o_wb_cti     <= CTI_SINGLE;
        end else begin
            // Per-beat and per-command strobes last exactly one cycle.
            bus.o_rdat_valid <= 1'b0;
            bus.o_rdat_last  <= 1'b0;
            bus.o_done       <= 1'b0;
            bus.o_err        <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_cmd_valid) begin
                        bus.o_cmd_ready <= 1'b0;
                        bus.o_wb_adr    <= bus.i_cmd_adr & ~32'h3;
                        bus.o_wb_sel    <= bus.i_cmd_sel;
                        bus.o_wb_we     <= bus.i_cmd_we;
                        bus.o_wb_cti    <= (bus.i_cmd_len == '0) ? CTI_SINGLE : CTI_INCR;
                        beat_cnt        <= bus.i_cmd_len;
                        tmo_cnt         <= '0;
                        if (bus.i_cmd_we) begin
                            bus.o_wdat_ready <= 1'b1;
                            state            <= WDAT;
                        end else begin
                            bus.o_wb_cyc <= 1'b1;
                            bus.o_wb_stb <= 1'b1;
                            state        <= BUS;
                        end
                    end
                end

                WDAT: begin
                    if (bus.i_wdat_valid) begin
                        bus.o_wb_dat     <= bus.i_wdat;
                        bus.o_wdat_ready <= 1'b0;
                        bus.o_wb_cyc     <= 1'b1;
                        bus.o_wb_stb     <= 1'b1;
                        tmo_cnt          <= '0;
                        state            <= BUS;
                    end
                end

                BUS: begin
                    // An ack in the terminal-count cycle still completes the beat.
                    if (bus.i_wb_ack) begin
                        tmo_cnt <= '0;
                        if (!bus.o_wb_we) begin
                            bus.o_rdat       <= bus.i_wb_dat;
                            bus.o_rdat_valid <= 1'b1;
                            bus.o_rdat_last  <= (beat_cnt == '0);
                        end
                        if (beat_cnt != '0) begin
                            bus.o_wb_adr <= bus.o_wb_adr + 32'd4;
                            beat_cnt     <= beat_cnt - LEN_W'(1);
                            bus.o_wb_cti <= (beat_cnt == LEN_W'(1)) ? CTI_END : CTI_INCR;
                            if (bus.o_wb_we) begin
                                bus.o_wb_stb     <= 1'b0;
                                bus.o_wdat_ready <= 1'b1;
                                state            <= WDAT;
                            end
                        end else begin
                            bus.o_wb_cyc <= 1'b0;
                            bus.o_wb_stb <= 1'b0;
                            bus.o_done   <= 1'b1;
                            state        <= DONE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.o_wb_cyc <= 1'b0;
                        bus.o_wb_stb <= 1'b0;
                        bus.o_done   <= 1'b1;
                        bus.o_err    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                DONE: begin
                    bus.o_cmd_ready <= 1'b1;
                    state           <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_model_wb_initiator.sv
// Directed bench for model_wb_initiator: a RAM-backed Wishbone slave with optional
// random stalls, plus per-scenario tasks that check bus beats, read data and status.
module tb_model_wb_initiator;

    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    model_wb_initiator_if #(.LEN_W(LEN_W)) bus ();

    model_wb_initiator #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];
    logic        preloaded = 1'b0;
    logic        ack_en = 1'b1;
    logic        stall_mode = 1'b0;
    int          stall_run = 0;
    logic [9:0]  widx;

    logic [31:0] beat_adr [$];
    logic [2:0]  beat_cti [$];
    logic        beat_we  [$];
    logic [31:0] rd_dat   [$];
    logic        rd_last  [$];
    logic        done_err [$];
    int          done_cnt = 0;

    logic [31:0] wtbl [0:63];
    int          wr_wr = 0;
    int          wr_rd = 0;

    // Slave, monitors and write-data source share one negedge process.
    always @(negedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
            mem[64]  = 32'hDEADBEEF;
            mem[128] = 32'hA0000001; mem[129] = 32'hB0000002;
            mem[130] = 32'hC0000003; mem[131] = 32'hD0000004;
            mem[192] = 32'hAABBCCDD; mem[193] = 32'h01020304; mem[194] = 32'hF0E0D0C0;
            mem[0]   = 32'hCAFEF00D;
            preloaded = 1'b1;
        end
        if (bus.o_rdat_valid) begin
            rd_dat.push_back(bus.o_rdat);
            rd_last.push_back(bus.o_rdat_last);
        end
        if (bus.o_done) begin
            done_err.push_back(bus.o_err);
            done_cnt++;
        end
        if (bus.o_wb_cyc && bus.o_wb_stb && ack_en && !rst) begin
            if (stall_mode && stall_run < 4 && $urandom_range(0, 1) == 1) begin
                bus.i_wb_ack = 1'b0;
                stall_run++;
            end else begin
                stall_run = 0;
                bus.i_wb_ack = 1'b1;
                widx = bus.o_wb_adr[11:2];
                if (bus.o_wb_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.o_wb_sel[b]) mem[widx][8*b +: 8] = bus.o_wb_dat[8*b +: 8];
                end else begin
                    bus.i_wb_dat = mem[widx];
                end
                beat_adr.push_back(bus.o_wb_adr);
                beat_cti.push_back(bus.o_wb_cti);
                beat_we.push_back(bus.o_wb_we);
            end
        end else begin
            bus.i_wb_ack = 1'b0;
        end
        if (rst) wr_rd = wr_wr;
        if (bus.o_wdat_ready && !rst && wr_rd < wr_wr) begin
            bus.i_wdat_valid = 1'b1;
            bus.i_wdat = wtbl[wr_rd];
            wr_rd++;
        end else begin
            bus.i_wdat_valid = 1'b0;
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [LEN_W-1:0] len, output logic ok);
        bus.i_cmd_we = we; bus.i_cmd_adr = adr; bus.i_cmd_sel = sel; bus.i_cmd_len = len;
        bus.i_cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.o_cmd_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            if (done_cnt >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.o_cmd_ready); end
        total++; if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we} !== 3'b000) begin bad++; $display("FAIL reset_cyc_stb_we got=%b exp=000", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we}); end
        total++; if ({bus.o_done, bus.o_err, bus.o_rdat_valid, bus.o_rdat_last, bus.o_wdat_ready} !== 5'b0) begin bad++; $display("FAIL reset_status got=%b exp=00000", {bus.o_done, bus.o_err, bus.o_rdat_valid, bus.o_rdat_last, bus.o_wdat_ready}); end
        total++; if (bus.o_wb_adr !== 32'h0 || bus.o_wb_cti !== 3'b0 || bus.o_wb_sel !== 4'h0 || bus.o_wb_bte !== 2'b0 || bus.o_wb_dat !== 32'h0 || bus.o_rdat !== 32'h0) begin
            bad++; $display("FAIL reset_bus_fields adr=%h cti=%b sel=%h bte=%b dat=%h rdat=%h exp all 0", bus.o_wb_adr, bus.o_wb_cti, bus.o_wb_sel, bus.o_wb_bte, bus.o_wb_dat, bus.o_rdat);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        int b0 = beat_adr.size(); int r0 = rd_dat.size(); int d0 = done_cnt;
        logic ok;
        stall_mode = 1'b0;
        issue(1'b0, 32'h100, 4'hF, 4'd0, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_accept got=timeout exp=accepted"); end
        wait_done(d0 + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_done got=timeout exp=done"); end
        total++; if (beat_adr.size() != b0 + 1 || beat_adr[b0] !== 32'h100 || beat_cti[b0] !== 3'b000) begin
            bad++; $display("FAIL single_beat n=%0d adr=%h cti=%b exp n=1 adr=100 cti=000", beat_adr.size() - b0, beat_adr[b0], beat_cti[b0]);
        end
        total++; if (rd_dat.size() != r0 + 1 || rd_dat[r0] !== 32'hDEADBEEF || rd_last[r0] !== 1'b1) begin
            bad++; $display("FAIL single_rdat n=%0d dat=%h last=%b exp n=1 dat=deadbeef last=1", rd_dat.size() - r0, rd_dat[r0], rd_last[r0]);
        end
        total++; if (done_err[d0] !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", done_err[d0]); end
    endtask

    task automatic test_burst_read;
        int b0 = beat_adr.size(); int r0 = rd_dat.size(); int d0 = done_cnt;
        logic ok;
        logic [31:0] exp_d [4] = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
        stall_mode = 1'b1;
        issue(1'b0, 32'h202, 4'hF, 4'd3, ok);
        total++; if (!ok) begin bad++; $display("FAIL burst_accept got=timeout exp=accepted"); end
        wait_done(d0 + 1, ok);
        stall_mode = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL burst_done got=timeout exp=done"); end
        total++; if (beat_adr.size() != b0 + 4 || rd_dat.size() != r0 + 4) begin
            bad++; $display("FAIL burst_counts beats=%0d rdats=%0d exp 4 4", beat_adr.size() - b0, rd_dat.size() - r0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (beat_adr[b0+i] !== 32'h200 + 32'(4*i) || beat_cti[b0+i] !== ((i == 3) ? 3'b111 : 3'b010)) begin
                    bad++; $display("FAIL burst_beat%0d adr=%h cti=%b exp adr=%h cti=%b", i, beat_adr[b0+i], beat_cti[b0+i], 32'h200 + 32'(4*i), (i == 3) ? 3'b111 : 3'b010);
                end
                total++; if (rd_dat[r0+i] !== exp_d[i] || rd_last[r0+i] !== (i == 3)) begin
                    bad++; $display("FAIL burst_rdat%0d dat=%h last=%b exp dat=%h last=%b", i, rd_dat[r0+i], rd_last[r0+i], exp_d[i], i == 3);
                end
            end
        end
        total++; if (done_err[d0] !== 1'b0) begin bad++; $display("FAIL burst_err got=%b exp=0", done_err[d0]); end
    endtask

    task automatic test_write_sel;
        int b0 = beat_adr.size(); int r0 = rd_dat.size(); int d0 = done_cnt;
        logic ok;
        wtbl[wr_wr] = 32'h11223344; wtbl[wr_wr+1] = 32'h55667788; wtbl[wr_wr+2] = 32'h99AABBCC;
        wr_wr = wr_wr + 3;
        stall_mode = 1'b1;
        issue(1'b1, 32'h300, 4'b0101, 4'd2, ok);
        total++; if (!ok) begin bad++; $display("FAIL write_accept got=timeout exp=accepted"); end
        wait_done(d0 + 1, ok);
        stall_mode = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL write_done got=timeout exp=done"); end
        total++; if (done_err[d0] !== 1'b0 || rd_dat.size() != r0) begin bad++; $display("FAIL write_status err=%b rdats=%0d exp err=0 rdats=0", done_err[d0], rd_dat.size() - r0); end
        total++; if (beat_adr.size() != b0 + 3 || beat_cti[b0] !== 3'b010 || beat_cti[b0+1] !== 3'b010 || beat_cti[b0+2] !== 3'b111 || beat_we[b0+2] !== 1'b1 || beat_adr[b0+2] !== 32'h308) begin
            bad++; $display("FAIL write_beats n=%0d cti=%b,%b,%b last_adr=%h exp n=3 cti=010,010,111 last_adr=308", beat_adr.size() - b0, beat_cti[b0], beat_cti[b0+1], beat_cti[b0+2], beat_adr[b0+2]);
        end
        total++; if (mem[192] !== 32'hAA22CC44 || mem[193] !== 32'h01660388 || mem[194] !== 32'hF0AAD0CC) begin
            bad++; $display("FAIL write_ram got=%h %h %h exp=aa22cc44 01660388 f0aad0cc", mem[192], mem[193], mem[194]);
        end
        issue(1'b0, 32'h300, 4'hF, 4'd0, ok);
        wait_done(d0 + 2, ok);
        total++; if (!ok || rd_dat.size() != r0 + 1 || rd_dat[r0] !== 32'hAA22CC44) begin
            bad++; $display("FAIL write_readback got=%h exp=aa22cc44", rd_dat[r0]);
        end
    endtask

    task automatic test_timeout;
        int b0 = beat_adr.size(); int r0 = rd_dat.size(); int d0 = done_cnt;
        int n = 0;
        logic ok;
        logic low_seen = 1'b0;
        ack_en = 1'b0;
        issue(1'b0, 32'h40, 4'hF, 4'd1, ok);
        total++; if (!ok) begin bad++; $display("FAIL timeout_accept got=timeout exp=accepted"); end
        for (int i = 0; i < 100 && !low_seen; i++) begin
            @(negedge clk);
            if (bus.o_wb_stb) n++; else low_seen = 1'b1;
        end
        total++; if (n != TIMEOUT || bus.o_wb_cyc !== 1'b0) begin bad++; $display("FAIL timeout_stb_cycles got=%0d cyc=%b exp=%0d cyc=0", n, bus.o_wb_cyc, TIMEOUT); end
        wait_done(d0 + 1, ok);
        ack_en = 1'b1;
        total++; if (!ok || done_err[d0] !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b exp=1", done_err[d0]); end
        total++; if (rd_dat.size() != r0 || beat_adr.size() != b0) begin bad++; $display("FAIL timeout_no_data rdats=%0d beats=%0d exp 0 0", rd_dat.size() - r0, beat_adr.size() - b0); end
    endtask

    task automatic test_reset_mid_burst;
        int b0 = beat_adr.size(); int r0; int d0 = done_cnt; int w0 = wr_rd;
        logic ok;
        for (int i = 0; i < 4; i++) wtbl[wr_wr+i] = 32'h70000000 + 32'(i);
        wr_wr = wr_wr + 4;
        issue(1'b1, 32'h380, 4'hF, 4'd3, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_accept got=timeout exp=accepted"); end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (wr_rd >= w0 + 2) break;
        end
        #1;
        total++; if (bus.o_wb_stb !== 1'b1 || beat_adr.size() != b0 + 1) begin bad++; $display("FAIL rstmid_in_beat2 stb=%b beats=%0d exp stb=1 beats=1", bus.o_wb_stb, beat_adr.size() - b0); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0 || bus.o_cmd_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_drop cyc=%b stb=%b ready=%b exp 0 0 1", bus.o_wb_cyc, bus.o_wb_stb, bus.o_cmd_ready);
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (done_cnt != d0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt - d0); end
        r0 = rd_dat.size();
        issue(1'b0, 32'h100, 4'hF, 4'd0, ok);
        wait_done(d0 + 1, ok);
        total++; if (!ok || rd_dat.size() != r0 + 1 || rd_dat[r0] !== 32'hDEADBEEF || done_err[d0] !== 1'b0) begin
            bad++; $display("FAIL rstmid_followup got=%h err=%b exp=deadbeef err=0", rd_dat[r0], done_err[d0]);
        end
    endtask

    task automatic test_back_to_back;
        int b0 = beat_adr.size(); int r0 = rd_dat.size(); int d0 = done_cnt;
        logic ok;
        logic got;
        wtbl[wr_wr] = 32'h5A5AA5A5;
        wr_wr = wr_wr + 1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin bus.i_cmd_we = 1'b0; bus.i_cmd_adr = 32'h0; end
                1:       begin bus.i_cmd_we = 1'b1; bus.i_cmd_adr = 32'h4; end
                default: begin bus.i_cmd_we = 1'b0; bus.i_cmd_adr = 32'h4; end
            endcase
            bus.i_cmd_sel = 4'hF; bus.i_cmd_len = 4'd0; bus.i_cmd_valid = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                if (bus.o_cmd_ready) got = 1'b1;
            end
            @(posedge clk); #1;
            total++; if (!got || done_cnt - d0 != k) begin bad++; $display("FAIL b2b_accept%0d dones_before=%0d exp=%0d", k, done_cnt - d0, k); end
        end
        bus.i_cmd_valid = 1'b0;
        wait_done(d0 + 3, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_done got=timeout exp=3 dones"); end
        total++; if (rd_dat.size() != r0 + 2 || rd_dat[r0] !== 32'hCAFEF00D || rd_dat[r0+1] !== 32'h5A5AA5A5) begin
            bad++; $display("FAIL b2b_rdat n=%0d d0=%h d1=%h exp n=2 cafef00d 5a5aa5a5", rd_dat.size() - r0, rd_dat[r0], rd_dat[r0+1]);
        end
        total++; if (beat_adr.size() != b0 + 3 || beat_adr[b0+1] !== 32'h4 || beat_we[b0+1] !== 1'b1 || beat_cti[b0+2] !== 3'b000) begin
            bad++; $display("FAIL b2b_beats n=%0d adr1=%h we1=%b cti2=%b exp n=3 adr1=4 we1=1 cti2=000", beat_adr.size() - b0, beat_adr[b0+1], beat_we[b0+1], beat_cti[b0+2]);
        end
        total++; if (done_err[d0] !== 1'b0 || done_err[d0+1] !== 1'b0 || done_err[d0+2] !== 1'b0 || mem[1] !== 32'h5A5AA5A5) begin
            bad++; $display("FAIL b2b_status err=%b%b%b ram=%h exp err=000 ram=5a5aa5a5", done_err[d0], done_err[d0+1], done_err[d0+2], mem[1]);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_we    = 1'b0;
        bus.i_cmd_adr   = 32'h0;
        bus.i_cmd_sel   = 4'h0;
        bus.i_cmd_len   = '0;
        test_reset;
        test_single_read;
        test_burst_read;
        test_write_sel;
        test_timeout;
        test_reset_mid_burst;
        test_back_to_back;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
